// File: rtl/sw_tile_link.sv
// sw_tile_link: byte link from software that writes tiles into the tile map.
// Each exchange is a four-phase handshake on to_hw_sig and to_sw_sig.
// A packet is three bytes in the order x, y, id. The packet becomes one
// tile-map write, or raises an error if the coordinates are off the map.
// A commit swaps the frame buffers.
// Optional feature: define SW_TILE_LINK_TIMEOUT_EN to discard a partial
// packet that stalls for TIMEOUT_CYC cycles.
module sw_tile_link #(
  parameter int MAP_W       = 20,
  parameter int MAP_H       = 15,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [1:0] to_hw_sig,
  input  logic [7:0] to_hw_data,
  output logic [1:0] to_sw_sig,
  output logic       map_we,
  output logic [8:0] map_addr,
  output logic [7:0] map_id,
  output logic       frame_swap,
  output logic       pkt_err
);

  localparam logic [8:0] MAP_W9 = 9'(MAP_W);
  localparam logic [8:0] MAP_H9 = 9'(MAP_H);

  typedef enum logic [1:0] {IDLE, BYTE_ACK, COMMIT_ACK, ERR_ACK} state_e;

  state_e      state_q;
  logic [1:0]  sig_q;
  logic [7:0]  data_q;
  logic [1:0]  byte_cnt_q;
  logic [7:0]  x_q, y_q;
  logic [1:0]  to_sw_q;
  logic        map_we_q, frame_swap_q, pkt_err_q;
  logic [8:0]  map_addr_q;
  logic [7:0]  map_id_q;

  // The third byte (id) is taken straight from data_q. The address is
  // unsigned 9-bit. It is only used when both coordinates are on the map.
  logic [8:0]  addr_d;
  logic        legal_d;
  assign addr_d  = 9'(y_q) * MAP_W9 + 9'(x_q);
  assign legal_d = ({1'b0, x_q} < MAP_W9) && ({1'b0, y_q} < MAP_H9);

`ifdef SW_TILE_LINK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;
`endif

  // Input capture: the FSM only ever looks at these registered copies.
  always_ff @(posedge clk50) begin
    if (reset) begin
      sig_q  <= 2'b00;
      data_q <= 8'h00;
    end else begin
      sig_q  <= to_hw_sig;
      data_q <= to_hw_data;
    end
  end

  // Handshake FSM. It also assembles packets and drives the registered
  // outputs. Reset has priority, so it also kills any strobe due this cycle.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q      <= IDLE;
      to_sw_q      <= 2'b00;
      byte_cnt_q   <= 2'd0;
      x_q          <= 8'h00;
      y_q          <= 8'h00;
      map_we_q     <= 1'b0;
      frame_swap_q <= 1'b0;
      map_addr_q   <= 9'd0;
      map_id_q     <= 8'h00;
      pkt_err_q    <= 1'b0;
`ifdef SW_TILE_LINK_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      map_we_q     <= 1'b0;
      frame_swap_q <= 1'b0;
`ifdef SW_TILE_LINK_TIMEOUT_EN
      // The stall counter only survives a cycle while idle with a partial packet.
      to_cnt_q     <= '0;
`endif
      case (state_q)
        IDLE: begin
          case (sig_q)
            2'b01: begin
              if (byte_cnt_q == 2'd0) begin
                x_q        <= data_q;
                byte_cnt_q <= 2'd1;
                state_q    <= BYTE_ACK;
                to_sw_q    <= 2'b01;
              end else if (byte_cnt_q == 2'd1) begin
                y_q        <= data_q;
                byte_cnt_q <= 2'd2;
                state_q    <= BYTE_ACK;
                to_sw_q    <= 2'b01;
              end else begin
                byte_cnt_q <= 2'd0;
                if (legal_d) begin
                  map_we_q   <= 1'b1;
                  map_addr_q <= addr_d;
                  map_id_q   <= data_q;
                  state_q    <= BYTE_ACK;
                  to_sw_q    <= 2'b01;
                end else begin
                  pkt_err_q  <= 1'b1;
                  state_q    <= ERR_ACK;
                  to_sw_q    <= 2'b11;
                end
              end
            end
            2'b10: begin
              if (byte_cnt_q == 2'd0) begin
                frame_swap_q <= 1'b1;
                pkt_err_q    <= 1'b0;
                state_q      <= COMMIT_ACK;
                to_sw_q      <= 2'b10;
              end else begin
                byte_cnt_q   <= 2'd0;
                pkt_err_q    <= 1'b1;
                state_q      <= ERR_ACK;
                to_sw_q      <= 2'b11;
              end
            end
            2'b11: begin
              byte_cnt_q <= 2'd0;
              state_q    <= BYTE_ACK;
              to_sw_q    <= 2'b01;
            end
            default: begin
`ifdef SW_TILE_LINK_TIMEOUT_EN
              if (byte_cnt_q != 2'd0) begin
                if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                  byte_cnt_q <= 2'd0;
                  pkt_err_q  <= 1'b1;
                end else begin
                  to_cnt_q   <= to_cnt_q + 1'b1;
                end
              end
`endif
            end
          endcase
        end
        default: begin
          // Every ack state holds until software drops back to idle.
          if (sig_q == 2'b00) begin
            state_q <= IDLE;
            to_sw_q <= 2'b00;
          end
        end
      endcase
    end
  end

  assign to_sw_sig  = to_sw_q;
  assign map_we     = map_we_q;
  assign map_addr   = map_addr_q;
  assign map_id     = map_id_q;
  assign frame_swap = frame_swap_q;
  assign pkt_err    = pkt_err_q;

endmodule

// File: doc/sw_tile_link.md
SW_TILE_LINK -- requirements
Module: sw_tile_link

Interface
REQ-001 SHALL have parameter MAP_W, default 20, meaning tile columns (640/32).
REQ-002 SHALL have parameter MAP_H, default 15, meaning tile rows (480/32).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50000, meaning mid-packet stall limit in clk50 cycles.
REQ-004 SHALL have port clk50  input  1  the single 50 MHz clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port to_hw_sig  input  2  software command: 00 idle, 01 byte valid, 10 commit frame, 11 abort packet.
REQ-007 SHALL have port to_hw_data  input  8  software byte, valid while to_hw_sig=01.
REQ-008 SHALL have port to_sw_sig  output  2  hardware reply: 00 ready, 01 byte ack, 10 commit ack, 11 error ack.
REQ-009 SHALL have port map_we  output  1  one-cycle tile-map write strobe.
REQ-010 SHALL have port map_addr  output  9  tile index y*MAP_W+x.
REQ-011 SHALL have port map_id  output  8  tile ID to write.
REQ-012 SHALL have port frame_swap  output  1  one-cycle pulse telling the tile renderer to swap map buffers.
REQ-013 SHALL have port pkt_err  output  1  sticky error flag, cleared by accepted commit.

Function
REQ-014 SHALL register to_hw_sig and to_hw_data once (sig_q, data_q); FSM acts only on registered values; to_sw_sig is a registered output (2-cycle response from to_hw_sig change).
REQ-015 SHALL implement states IDLE, BYTE_ACK, COMMIT_ACK, ERR_ACK.
REQ-016 IDLE: to_sw_sig=00; sig_q=01 -> capture data_q into slot byte_cnt, go BYTE_ACK; sig_q=10 -> COMMIT_ACK; sig_q=11 -> clear byte_cnt, go BYTE_ACK; sig_q=00 -> stay.
REQ-017 BYTE_ACK drives 01, COMMIT_ACK drives 10, ERR_ACK drives 11; each returns to IDLE only when sig_q=00 (four-phase handshake); no byte captured while not in IDLE.
REQ-018 Packet = 3 bytes in order x, y, id; byte_cnt counts 0,1,2 and wraps to 0 after third byte.
REQ-019 On third byte with x<MAP_W and y<MAP_H: map_we=1 for exactly one cycle, the same cycle to_sw_sig first shows 01, with map_addr=y*MAP_W+x and map_id=id.
REQ-020 On third byte with x>=MAP_W or y>=MAP_H: no write, pkt_err set, go ERR_ACK instead of BYTE_ACK.
REQ-021 Commit with byte_cnt=0: frame_swap=1 one cycle (cycle COMMIT_ACK is entered), pkt_err cleared.
REQ-022 Commit with byte_cnt!=0: no frame_swap, partial packet discarded, byte_cnt=0, pkt_err set, go ERR_ACK.
REQ-023 map_addr and map_id SHALL hold last written values between strobes; map_we, frame_swap otherwise 0.
REQ-024 Address arithmetic SHALL be unsigned, computed in 9 bits; max legal value MAP_W*MAP_H-1 = 299.

Reset
REQ-025 On reset: state IDLE, to_sw_sig=00, map_we=0, frame_swap=0, map_addr=0, map_id=0, pkt_err=0, byte_cnt=0, sig_q=00, data_q=0, timeout counter=0.
REQ-026 Reset asserted mid-packet or mid-handshake SHALL discard partial packet and suppress any pending strobe in that cycle.

Configuration
REQ-027 Macro SW_TILE_LINK_TIMEOUT_EN: when defined, a counter runs while in IDLE with byte_cnt!=0, clears on any captured byte/abort/commit, and at TIMEOUT_CYC cycles discards the partial packet (byte_cnt=0) and sets pkt_err; when undefined no counter exists and a partial packet waits indefinitely.

Verification
REQ-028 Bytes 3,2,0x41 each with full handshake -> one map_we with map_addr=43, map_id=0x41; to_sw_sig 00->01->00 per byte.
REQ-029 Bytes 20,0,0x05 -> no map_we, to_sw_sig=11 on third byte, pkt_err=1; then commit -> frame_swap pulse, to_sw_sig=10, pkt_err=0.
REQ-030 Bytes 1,1 then commit -> no frame_swap, to_sw_sig=11, pkt_err=1; next bytes 19,14,0xFF -> map_addr=299.
REQ-031 to_hw_sig held 01 for 100 cycles -> exactly one byte captured, to_sw_sig stays 01 until to_hw_sig=00.
REQ-032 Byte 5, then abort (11), then bytes 0,0,7 -> map_addr=0, map_id=7; reset pulse between bytes 2 and 3 of a packet -> no write, outputs at reset values.
REQ-033 With SW_TILE_LINK_TIMEOUT_EN, TIMEOUT_CYC=16: one byte then 16 idle cycles -> pkt_err=1, next 3 bytes form a fresh packet.
